// File: rtl/seg_display_share_arbiter_if.sv
// seg_display_share_arbiter_if: requester/display bundle for the display share arbiter.
// The master side drives requests and values; the slave side is the arbiter.
interface seg_display_share_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [13*NREQ-1:0]   value;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [12:0]          num_out;
    logic                 num_valid;
    logic [IDW-1:0]       active_id;

    modport master (
        output req,
        output value,
        input  grant,
        input  done,
        input  num_out,
        input  num_valid,
        input  active_id
    );

    modport slave (
        input  req,
        input  value,
        output grant,
        output done,
        output num_out,
        output num_valid,
        output active_id
    );
endinterface

// File: rtl/seg_display_share_arbiter.sv
// seg_display_share_arbiter: round-robin time-share of the four-digit display.
// Each granted requester's value is latched onto num_out for HOLD_CYCLES cycles.
// Optional blank gap between slots is compiled in with DISP_ARB_GAP_EN.
module seg_display_share_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000
) (
    input logic                        clk,
    input logic                        rst_n,
    seg_display_share_arbiter_if.slave bus
);
    localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One counter serves both the hold and the gap, so size it for the larger.
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StShow = 2'd1;
`ifdef DISP_ARB_GAP_EN
    localparam logic [1:0] StGap  = 2'd2;
`endif

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [12:0]     num_q, num_d;
    logic            valid_q, valid_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sel_found;
    int unsigned     sel_pos;
    int unsigned     cand;

    // Round-robin search: first asserted request at or after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_pos   = 0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_pos   = cand;
            end
        end
    end

    // Slot sequencing: arbitrate in idle, hold in show, optionally blank in gap.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        num_d   = num_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d = NREQ'(1) << sel_pos;
                    id_d    = IDW'(sel_pos);
                    num_d   = bus.value[13*sel_pos +: 13];
                    valid_d = 1'b1;
                    ptr_d   = (sel_pos == NREQ - 1) ? '0 : IDW'(sel_pos + 1);
                    cnt_d   = '0;
                    state_d = StShow;
                end
            end
            StShow: begin
                cnt_d = cnt_q + 1'b1;
                // Early release takes priority: a dropped request never earns done.
                if (!bus.req[id_q] || cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    done_d  = bus.req[id_q] ? grant_q : '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
`ifdef DISP_ARB_GAP_EN
                    state_d = StGap;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef DISP_ARB_GAP_EN
            StGap: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything including the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.num_out   = num_q;
    assign bus.num_valid = valid_q;
    assign bus.active_id = id_q;

endmodule

// File: tb/tb_seg_display_share_arbiter.sv
// tb_seg_display_share_arbiter: directed bench for the display share arbiter.
// A slot-level model predicts the outputs every cycle; literal checks pin key points.
module tb_seg_display_share_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 3;
`ifdef DISP_ARB_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_display_share_arbiter_if #(.NREQ(NREQ)) bus ();

    seg_display_share_arbiter #(
        .NREQ       (NREQ),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Slot-level model: owner of the display, remaining show and blank cycles.
    int          m_owner = -1;
    int          m_left  = 0;
    int          m_blank = 0;
    int          m_ptr   = 0;
    int          m_done  = -1;
    int          m_vid   = 0;
    logic [12:0] m_num   = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_left = 0; m_blank = 0; m_ptr = 0;
                m_done = -1; m_vid = 0; m_num = '0;
            end else begin
                m_done = -1;
                if (m_owner >= 0) begin
                    m_left = m_left - 1;
                    if (!bus.req[m_owner] || m_left == 0) begin
                        if (bus.req[m_owner]) m_done = m_owner;
                        m_owner = -1;
                        m_blank = GAP_EN ? GAP : 0;
                    end
                end else if (m_blank > 0) begin
                    m_blank = m_blank - 1;
                end else if (bus.req != 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (m_owner < 0 && bus.req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                    end
                    m_left = HOLD;
                    m_vid  = m_owner;
                    m_num  = bus.value[13*m_owner +: 13];
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
        end
    end

    // Slot recorder for literal checks: start value/id and length of each slot.
    int q_num[$];
    int q_id[$];
    int q_len[$];
    int run_len = 0;
    bit prev_v  = 1'b0;

    // Compare process: every cycle out of reset, outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("grant", int'(bus.grant), (m_owner >= 0) ? (1 << m_owner) : 0);
                chk("done", int'(bus.done), (m_done >= 0) ? (1 << m_done) : 0);
                chk("num_valid", int'(bus.num_valid), (m_owner >= 0) ? 1 : 0);
                chk("num_out", int'(bus.num_out), int'(m_num));
                if (bus.num_valid) chk("active_id", int'(bus.active_id), m_vid);
                chk("grant_done_overlap", int'(bus.grant & bus.done), 0);
                if (bus.num_valid && !prev_v) begin
                    q_num.push_back(int'(bus.num_out));
                    q_id.push_back(int'(bus.active_id));
                    run_len = 0;
                end
                if (bus.num_valid) run_len++;
                if (!bus.num_valid && prev_v) q_len.push_back(run_len);
                prev_v = bus.num_valid;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        q_num.delete(); q_id.delete(); q_len.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!bus.num_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(bus.num_valid), 1);
    endtask

    task automatic wait_done(input string nm, input int budget, input int hold_num);
        int n = 0;
        while (bus.done == '0 && n < budget) begin
            if (hold_num >= 0 && bus.num_valid) chk({nm, "_hold"}, int'(bus.num_out), hold_num);
            @(negedge clk);
            n++;
        end
        chk({nm, "_seen"}, (bus.done != '0) ? 1 : 0, 1);
    endtask

    initial begin
        int exp_num[5] = '{11, 22, 33, 44, 11};
        int exp_id[5]  = '{0, 1, 2, 3, 0};
        int n;
        int blank;

        bus.req = '0;
        bus.value = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_num", int'(bus.num_out), 0);
        chk("rst_valid", int'(bus.num_valid), 0);
        chk("rst_id", int'(bus.active_id), 0);
        rst_n = 1'b1;

        // Single requester: one-cycle grant latency, 8-cycle slot, done pulse
        @(negedge clk);
        bus.value[12:0] = 13'd1234;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t1_grant", int'(bus.grant), 1);
        chk("t1_num", int'(bus.num_out), 1234);
        chk("t1_valid", int'(bus.num_valid), 1);
        wait_done("t1_done", 20, 1234);
        chk("t1_done_vec", int'(bus.done), 1);
        chk("t1_valid_fall", int'(bus.num_valid), 0);
        bus.req = '0;
        #1;
        chk("t1_len", (q_len.size() > 0) ? q_len[0] : -1, 8);

        // All four requesting: strict rotation 0,1,2,3,0
        do_reset();
        bus.value = {13'd44, 13'd33, 13'd22, 13'd11};
        bus.req = 4'b1111;
        n = 0;
        while (q_len.size() < 5 && n < 120) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("t2_slots", (q_len.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_num", (q_num.size() > i) ? q_num[i] : -1, exp_num[i]);
            chk("t2_id", (q_id.size() > i) ? q_id[i] : -1, exp_id[i]);
            chk("t2_len", (q_len.size() > i) ? q_len[i] : -1, HOLD);
        end
        bus.req = '0;

        // Value change mid-slot is not seen on num_out
        do_reset();
        bus.value = '0;
        bus.value[12:0] = 13'd100;
        bus.req = 4'b0001;
        wait_valid("t3_grant", 10);
        bus.value[12:0] = 13'd200;
        wait_done("t3_done", 20, 100);
        chk("t3_after", int'(bus.num_out), 100);
        bus.req = '0;

        // Early release at slot cycle 3: no done, next requester by pointer
        do_reset();
        bus.value = '0;
        bus.value[12:0]  = 13'd5;
        bus.value[25:13] = 13'd6;
        bus.req = 4'b0011;
        wait_valid("t4_grant", 10);
        chk("t4_id0", int'(bus.active_id), 0);
        repeat (3) @(negedge clk);
        chk("t4_still", int'(bus.num_valid), 1);
        bus.req = 4'b0010;
        @(negedge clk);
        chk("t4_fall", int'(bus.num_valid), 0);
        chk("t4_nodone", int'(bus.done), 0);
        wait_valid("t4_next", 20);
        chk("t4_id1", int'(bus.active_id), 1);
        chk("t4_num1", int'(bus.num_out), 6);
        bus.req = '0;

        // Asynchronous reset mid-slot, then arbitration restarts from index 0
        do_reset();
        bus.value = '0;
        bus.value[38:26] = 13'd8191;
        bus.value[51:39] = 13'd77;
        bus.req = 4'b0100;
        wait_valid("t5_grant", 10);
        chk("t5_num", int'(bus.num_out), 8191);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.req = 4'b1100;
        #1;
        chk("t5_rst_num", int'(bus.num_out), 0);
        chk("t5_rst_grant", int'(bus.grant), 0);
        chk("t5_rst_valid", int'(bus.num_valid), 0);
        chk("t5_rst_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t5_regrant", 10);
        chk("t5_id", int'(bus.active_id), 2);
        chk("t5_num2", int'(bus.num_out), 8191);
        bus.req = '0;

        // Blank spacing between back-to-back slots
        do_reset();
        bus.value = '0;
        bus.value[12:0]  = 13'd7;
        bus.value[25:13] = 13'd9;
        bus.req = 4'b0011;
        wait_valid("t6_grant", 10);
        n = 0;
        while (bus.num_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        blank = 0;
        n = 0;
        while (!bus.num_valid && n < 20) begin
            blank++;
            @(negedge clk);
            n++;
        end
        chk("t6_blank", blank, GAP_EN ? GAP + 1 : 1);
        chk("t6_id", int'(bus.active_id), 1);
        chk("t6_num", int'(bus.num_out), 9);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
